// File: rtl/spi_adc_scan_sequencer.sv
// Purpose: sequences SPI-master register accesses to read NUM_CH ADC channels per scan and stream 16-bit results.
// Latency: busy one cycle after start/tick; each bus access 3 cycles; result one cycle after the SSO-off write.
// Backpressure: none on the result stream; start while busy is ignored, a timer tick while busy flags err_overrun.
module spi_adc_scan_sequencer #(
    parameter int         NUM_CH     = 8,
    parameter int         SLAVE_IDX  = 0,
    parameter logic [4:0] CMD_PREFIX = 5'b11000,
    parameter int         PERIOD     = 50000,
    parameter int         TIMEOUT    = 8191
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        auto_en,
    output logic        spi_select,
    output logic [2:0]  spi_addr,
    output logic        spi_write_n,
    output logic        spi_read_n,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata,
    input  logic        spi_dataavailable,
    output logic        res_valid,
    output logic [2:0]  res_chan,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        scan_done,
    output logic        err_timeout,
    output logic        err_overrun
);
    typedef enum logic [3:0] {
        IDLE, CLR_STAT, WR_SS, SSO_ON, TX0, WAIT0, RX0,
        TX1, WAIT1, RX1, SSO_OFF, EMIT, ABORT
    } state_t;

    localparam int                WCNT_W   = $clog2(TIMEOUT + 1) + 1;
    localparam logic [2:0]        LAST_CH  = 3'(NUM_CH - 1);
    localparam logic [15:0]       TICK_AT  = 16'(PERIOD - 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(TIMEOUT);

    state_t            state, state_nxt;
    logic [1:0]        phase;
    logic [WCNT_W-1:0] wcnt;
    logic [15:0]       timer;
    logic [2:0]        ch;
    logic [7:0]        hi, lo;
    logic              tick, scan_go, in_access, acc_end, drive, in_wait;
    logic              bus_wr, bus_rd;
    logic [2:0]        bus_addr;
    logic [15:0]       bus_wdata;

    assign tick      = auto_en && (timer == TICK_AT);
    assign scan_go   = (state == IDLE) && (start || tick);
    assign in_access = bus_wr | bus_rd;
    // Phase 2 is the idle slot of an access; the registered outputs are driven during phases 1 and 2.
    assign acc_end   = (phase == 2'd2);
    assign drive     = in_access && !acc_end;
    assign in_wait   = (state == WAIT0) || (state == WAIT1);

    // Next-state and register-access decode for the current state
    always_comb begin
        state_nxt = state;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        bus_addr  = 3'd0;
        bus_wdata = 16'h0000;
        case (state)
            IDLE:     if (scan_go) state_nxt = CLR_STAT;
            CLR_STAT: begin
                bus_wr = 1'b1; bus_addr = 3'd2;
                if (acc_end) state_nxt = WR_SS;
            end
            WR_SS: begin
                bus_wr = 1'b1; bus_addr = 3'd5; bus_wdata = 16'(1 << SLAVE_IDX);
                if (acc_end) state_nxt = SSO_ON;
            end
            SSO_ON: begin
                bus_wr = 1'b1; bus_addr = 3'd3; bus_wdata = 16'h0400;
                if (acc_end) state_nxt = TX0;
            end
            TX0: begin
                bus_wr = 1'b1; bus_addr = 3'd1; bus_wdata = {8'h00, CMD_PREFIX, ch};
                if (acc_end) state_nxt = WAIT0;
            end
            WAIT0: begin
                if (spi_dataavailable)     state_nxt = RX0;
                else if (wcnt == WAIT_MAX) state_nxt = ABORT;
            end
            RX0: begin
                bus_rd = 1'b1; bus_addr = 3'd0;
                if (acc_end) state_nxt = TX1;
            end
            TX1: begin
                bus_wr = 1'b1; bus_addr = 3'd1;
                if (acc_end) state_nxt = WAIT1;
            end
            WAIT1: begin
                if (spi_dataavailable)     state_nxt = RX1;
                else if (wcnt == WAIT_MAX) state_nxt = ABORT;
            end
            RX1: begin
                bus_rd = 1'b1; bus_addr = 3'd0;
                if (acc_end) state_nxt = SSO_OFF;
            end
            SSO_OFF: begin
                bus_wr = 1'b1; bus_addr = 3'd3;
                if (acc_end) state_nxt = EMIT;
            end
            EMIT:     state_nxt = (ch == LAST_CH) ? IDLE : WR_SS;
            ABORT: begin
                bus_wr = 1'b1; bus_addr = 3'd3;
                if (acc_end) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM state, access phase, wait counter, channel index and received bytes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            phase <= 2'd0;
            wcnt  <= '0;
            ch    <= 3'd0;
            hi    <= 8'h00;
            lo    <= 8'h00;
        end else begin
            state <= state_nxt;
            phase <= drive ? phase + 2'd1 : 2'd0;
            wcnt  <= in_wait ? wcnt + WCNT_W'(1) : '0;
            if (scan_go)
                ch <= 3'd0;
            else if (state == EMIT && ch != LAST_CH)
                ch <= ch + 3'd1;
            // Read data is captured on the second driven cycle of the read.
            if (state == RX0 && acc_end) hi <= spi_rdata[7:0];
            if (state == RX1 && acc_end) lo <= spi_rdata[7:0];
        end
    end

    // Free-running scan period timer, held at zero while auto scanning is disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            timer <= 16'h0000;
        else if (!auto_en || tick)
            timer <= 16'h0000;
        else
            timer <= timer + 16'd1;
    end

    // Registered peripheral bus, result stream and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_select  <= 1'b0;
            spi_write_n <= 1'b1;
            spi_read_n  <= 1'b1;
            spi_addr    <= 3'd0;
            spi_wdata   <= 16'h0000;
            res_valid   <= 1'b0;
            res_chan    <= 3'd0;
            res_data    <= 16'h0000;
            busy        <= 1'b0;
            scan_done   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            spi_select  <= drive;
            spi_write_n <= !(drive && bus_wr);
            spi_read_n  <= !(drive && bus_rd);
            spi_addr    <= drive ? bus_addr : 3'd0;
            spi_wdata   <= drive ? bus_wdata : 16'h0000;
            res_valid   <= (state == EMIT);
            if (state == EMIT) begin
                res_chan <= ch;
                res_data <= {hi, lo};
            end
            scan_done   <= (state == EMIT) && (ch == LAST_CH);
            busy        <= (state_nxt != IDLE);
            if (scan_go)
                err_timeout <= 1'b0;
            else if (in_wait && state_nxt == ABORT)
                err_timeout <= 1'b1;
            // A tick that cannot start a scan is dropped and only recorded.
            if (tick && state != IDLE)
                err_overrun <= 1'b1;
            else if (start && state == IDLE)
                err_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_adc_scan_sequencer.sv
// Purpose: randomized scoreboard bench for spi_adc_scan_sequencer with a behavioural SPI peripheral.
// Latency: expectations are queued at scan issue; monitors compare whenever the bus or result stream shows activity.
// Backpressure: none; the peripheral model answers each transmit after a configurable random delay.
`timescale 1ns/1ps
module tb_spi_adc_scan_sequencer;
    localparam int NCH = 2;
    localparam int SLV = 0;
    localparam int PER = 100;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        spi_select, spi_write_n, spi_read_n;
    logic [2:0]  spi_addr;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata = 16'h0000;
    logic        spi_dataavailable = 1'b0;
    logic        res_valid, busy, scan_done, err_timeout, err_overrun;
    logic [2:0]  res_chan;
    logic [15:0] res_data;

    spi_adc_scan_sequencer #(
        .NUM_CH(NCH), .SLAVE_IDX(SLV), .CMD_PREFIX(5'b11000), .PERIOD(PER), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .auto_en(auto_en),
        .spi_select(spi_select), .spi_addr(spi_addr), .spi_write_n(spi_write_n),
        .spi_read_n(spi_read_n), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
        .spi_dataavailable(spi_dataavailable), .res_valid(res_valid), .res_chan(res_chan),
        .res_data(res_data), .busy(busy), .scan_done(scan_done),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    localparam logic [45:0] RST_VEC = {1'b0, 1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 4'b0000};
    wire logic [45:0] outs = {spi_select, spi_write_n, spi_read_n, spi_addr, spi_wdata,
                              res_valid, res_chan, res_data, busy, scan_done, err_timeout, err_overrun};

    int   checks = 0, errors = 0, cyc = 0;
    acc_t exp_acc[$];
    logic [7:0]  rx_q[$];
    logic [18:0] exp_res[$];
    int   dly_min = 0, dly_max = 3, dly = 0;
    bit   dly_act = 0, no_resp = 0;
    logic [7:0] pend = 8'h00;
    int   tx_cyc = 0, tx1_cnt = 0, tmo_gap = -1, rise_cnt = 0, last_rise = -1;
    int   res_cnt = 0, done_cnt = 0, mon_run = 0;
    acc_t mon_cap, mon_cur;
    logic busy_prev = 1'b0, tmo_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic acc_t mk(input logic rd, input logic [2:0] addr, input logic [15:0] data);
        acc_t a;
        a.rd = rd; a.addr = addr; a.data = data;
        return a;
    endfunction

    // Reference model: the register accesses and results one complete scan must produce.
    task automatic expect_scan(input bit fixed);
        logic [7:0] b0, b1;
        exp_acc.push_back(mk(1'b0, 3'd2, 16'h0000));
        for (int c = 0; c < NCH; c++) begin
            b0 = fixed ? 8'hA5 : 8'($urandom);
            b1 = fixed ? 8'h3C : 8'($urandom);
            rx_q.push_back(b0);
            rx_q.push_back(b1);
            exp_acc.push_back(mk(1'b0, 3'd5, 16'(1 << SLV)));
            exp_acc.push_back(mk(1'b0, 3'd3, 16'h0400));
            exp_acc.push_back(mk(1'b0, 3'd1, {8'h00, 5'b11000, 3'(c)}));
            exp_acc.push_back(mk(1'b1, 3'd0, 16'h0000));
            exp_acc.push_back(mk(1'b0, 3'd1, 16'h0000));
            exp_acc.push_back(mk(1'b1, 3'd0, 16'h0000));
            exp_acc.push_back(mk(1'b0, 3'd3, 16'h0000));
            exp_res.push_back({3'(c), b0, b1});
        end
    endtask

    // A scan whose first byte never arrives: setup, command byte, then SSO released.
    task automatic expect_abort();
        exp_acc.push_back(mk(1'b0, 3'd2, 16'h0000));
        exp_acc.push_back(mk(1'b0, 3'd5, 16'(1 << SLV)));
        exp_acc.push_back(mk(1'b0, 3'd3, 16'h0400));
        exp_acc.push_back(mk(1'b0, 3'd1, {8'h00, 5'b11000, 3'd0}));
        exp_acc.push_back(mk(1'b0, 3'd3, 16'h0000));
    endtask

    task automatic access_done(input acc_t a);
        acc_t e, got;
        got = a;
        if (got.rd) got.data = 16'h0000;
        if (exp_acc.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_access actual rd=%0d addr=%0d data=%h required none", a.rd, a.addr, a.data);
        end else begin
            e = exp_acc.pop_front();
            check("bus_access", got, e);
        end
        if (!a.rd && a.addr == 3'd1) begin
            tx_cyc = cyc;
            if (a.data == 16'h0000) tx1_cnt++;
            if (!no_resp) begin
                pend    = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                dly     = $urandom_range(dly_max, dly_min);
                dly_act = 1'b1;
            end
        end
        if (a.rd && a.addr == 3'd0) spi_dataavailable = 1'b0;
    endtask

    // Peripheral model plus bus-protocol and result monitors, all sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (dly_act) begin
            if (dly == 0) begin
                spi_rdata         = {8'($urandom), pend};
                spi_dataavailable = 1'b1;
                dly_act           = 1'b0;
            end else begin
                dly--;
            end
        end
        if (!reset_n) begin
            mon_run = 0;
        end else if (spi_select) begin
            mon_cur = mk(!spi_read_n, spi_addr, spi_wdata);
            if (mon_run == 0) begin
                mon_cap = mon_cur;
                check("strobe_onehot", 64'(spi_write_n ^ spi_read_n), 64'd1);
            end else begin
                check("access_stable", mon_cur, mon_cap);
            end
            mon_run++;
        end else begin
            check("idle_strobes", {spi_write_n, spi_read_n}, 2'b11);
            if (mon_run != 0) begin
                check("access_len", mon_run, 2);
                access_done(mon_cap);
                mon_run = 0;
            end
        end
        if (res_valid) begin
            res_cnt++;
            if (exp_res.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result actual chan=%0d data=%h required none", res_chan, res_data);
            end else begin
                logic [18:0] e;
                e = exp_res.pop_front();
                check("result", {res_chan, res_data}, e);
                check("scan_done_on_last", scan_done, (e[18:16] == 3'(NCH - 1)));
            end
        end else if (scan_done) begin
            checks++; errors++;
            $display("FAIL scan_done_alone actual=1 required=0");
        end
        if (scan_done) done_cnt++;
        if (busy && !busy_prev) begin rise_cnt++; last_rise = cyc; end
        if (err_timeout && !tmo_prev) tmo_gap = cyc - tx_cyc;
        busy_prev = busy;
        tmo_prev  = err_timeout;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic until_cyc(input int t);
        while (cyc < t) cycles(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin cycles(1); n++; end
        check("idle_reached", busy, 0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_acc_left"}, exp_acc.size(), 0);
        check({tag, "_res_left"}, exp_res.size(), 0);
    endtask

    initial begin
        int n0, rbase, cbase, dbase, tbase;
        cycles(3);
        check("reset_state", outs, RST_VEC);
        reset_n = 1'b1;
        cycles(2);

        // Directed frame data, then a few randomized single scans.
        cbase = res_cnt; dbase = done_cnt;
        expect_scan(1'b1);
        pulse_start();
        check("busy_after_start", busy, 1);
        wait_idle(400);
        check_drained("basic");
        check("basic_results", res_cnt - cbase, NCH);
        check("basic_done", done_cnt - dbase, 1);
        for (int i = 0; i < 3; i++) begin
            expect_scan(1'b0);
            pulse_start();
            wait_idle(400);
        end
        check_drained("random");

        // Timeout: the peripheral never reports data.
        no_resp = 1'b1; tmo_gap = -1; cbase = res_cnt; dbase = done_cnt;
        expect_abort();
        pulse_start();
        wait_idle(300);
        check("timeout_flag", err_timeout, 1);
        check("timeout_wait_cycles", tmo_gap, 21);
        check("timeout_no_result", res_cnt - cbase, 0);
        check("timeout_no_done", done_cnt - dbase, 0);
        check_drained("timeout");
        no_resp = 1'b0;
        expect_scan(1'b0);
        pulse_start();
        check("timeout_cleared", err_timeout, 0);
        wait_idle(400);
        check_drained("after_timeout");

        // Periodic scans, a start coincident with a tick, and a start while busy.
        rbase = rise_cnt; cbase = res_cnt;
        n0 = cyc;
        expect_scan(1'b0);
        auto_en = 1'b1;
        until_cyc(n0 + 100);
        check("auto_scan1_start", last_rise, n0 + 100);
        expect_scan(1'b0);
        until_cyc(n0 + 200);
        check("auto_scan2_start", last_rise, n0 + 200);
        check("auto_no_overrun", err_overrun, 0);
        expect_scan(1'b0);
        until_cyc(n0 + 299);
        start = 1'b1;
        until_cyc(n0 + 300);
        start = 1'b0;
        check("coincident_start", last_rise, n0 + 300);
        until_cyc(n0 + 320);
        check("busy_mid_scan", busy, 1);
        pulse_start();
        until_cyc(n0 + 380);
        auto_en = 1'b0;
        check("auto_scan_count", rise_cnt - rbase, 3);
        check("auto_results", res_cnt - cbase, 3 * NCH);
        check("auto_overrun_clear", err_overrun, 0);
        check_drained("auto");

        // Slow peripheral stretches each scan past the period: ticks while busy are dropped.
        dly_min = 15; dly_max = 15;
        cycles(2);
        rbase = rise_cnt;
        n0 = cyc;
        expect_scan(1'b0);
        auto_en = 1'b1;
        until_cyc(n0 + 100);
        check("ovr_scan1_start", last_rise, n0 + 100);
        until_cyc(n0 + 250);
        check("ovr_flag", err_overrun, 1);
        check("ovr_not_queued", rise_cnt - rbase, 1);
        check("ovr_idle_between", busy, 0);
        expect_scan(1'b0);
        until_cyc(n0 + 300);
        check("ovr_scan2_start", last_rise, n0 + 300);
        auto_en = 1'b0;
        wait_idle(400);
        check("ovr_sticky", err_overrun, 1);
        dly_min = 0; dly_max = 3;
        expect_scan(1'b0);
        pulse_start();
        check("ovr_cleared_by_start", err_overrun, 0);
        wait_idle(400);
        check_drained("overrun");

        // Reset while waiting for the second byte of a frame.
        dly_min = 10; dly_max = 10;
        cbase = res_cnt; tbase = tx1_cnt;
        expect_scan(1'b0);
        pulse_start();
        begin
            int n = 0;
            while (tx1_cnt == tbase && n < 300) begin cycles(1); n++; end
        end
        check("reached_wait1", tx1_cnt, tbase + 1);
        reset_n = 1'b0;
        #1;
        check("mid_scan_reset", outs, RST_VEC);
        exp_acc.delete(); exp_res.delete(); rx_q.delete();
        dly_act = 1'b0; spi_dataavailable = 1'b0;
        cycles(2);
        check("reset_no_result", res_cnt - cbase, 0);
        reset_n = 1'b1;
        dly_min = 0; dly_max = 3;
        cycles(1);
        expect_scan(1'b0);
        pulse_start();
        wait_idle(400);
        check("post_reset_results", res_cnt - cbase, NCH);
        check_drained("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
